// File: rtl/axil_master_arbiter.sv
// axil_master_arbiter
// Two-requester AXI4-Lite arbiter in front of one shared AXI-Lite master port.
// One transaction is in flight at a time. Grants are round-robin between s0 and s1.
// Request channels are captured into registers, so the master sees them one cycle
// after the grant. Response channels are combinational pass-throughs to the
// granted requester.
//
// Ports
//   clk_i, reset_i        sole clock, synchronous active-high reset
//   s{0,1}_axil_aw*/w*    requester write address/data (valid in, ready out)
//   s{0,1}_axil_b*        requester write response (valid/resp out, ready in)
//   s{0,1}_axil_ar*       requester read address (valid in, ready out)
//   s{0,1}_axil_r*        requester read data (valid/data/resp out, ready in)
//   m_axil_*              shared master port toward the peripheral space
//   busy_o                high whenever the FSM is outside IDLE
//   grant_id_o            requester currently or most recently granted
//
// state  | meaning
// IDLE   | no transaction; arbitrate and accept one request
// W_REQ  | drive captured AW/W to master until both handshake
// W_RESP | pass B channel between master and granted requester
// R_REQ  | drive captured AR to master until handshake
// R_RESP | pass R channel between master and granted requester

module axil_master_arbiter #(
   parameter int addr_width_p = 32,
   parameter int data_width_p = 32
) (
   input  logic                        clk_i,
   input  logic                        reset_i,

   input  logic [addr_width_p-1:0]     s0_axil_awaddr,
   input  logic [2:0]                  s0_axil_awprot,
   input  logic                        s0_axil_awvalid,
   output logic                        s0_axil_awready,
   input  logic [data_width_p-1:0]     s0_axil_wdata,
   input  logic [data_width_p/8-1:0]   s0_axil_wstrb,
   input  logic                        s0_axil_wvalid,
   output logic                        s0_axil_wready,
   output logic [1:0]                  s0_axil_bresp,
   output logic                        s0_axil_bvalid,
   input  logic                        s0_axil_bready,
   input  logic [addr_width_p-1:0]     s0_axil_araddr,
   input  logic [2:0]                  s0_axil_arprot,
   input  logic                        s0_axil_arvalid,
   output logic                        s0_axil_arready,
   output logic [data_width_p-1:0]     s0_axil_rdata,
   output logic [1:0]                  s0_axil_rresp,
   output logic                        s0_axil_rvalid,
   input  logic                        s0_axil_rready,

   input  logic [addr_width_p-1:0]     s1_axil_awaddr,
   input  logic [2:0]                  s1_axil_awprot,
   input  logic                        s1_axil_awvalid,
   output logic                        s1_axil_awready,
   input  logic [data_width_p-1:0]     s1_axil_wdata,
   input  logic [data_width_p/8-1:0]   s1_axil_wstrb,
   input  logic                        s1_axil_wvalid,
   output logic                        s1_axil_wready,
   output logic [1:0]                  s1_axil_bresp,
   output logic                        s1_axil_bvalid,
   input  logic                        s1_axil_bready,
   input  logic [addr_width_p-1:0]     s1_axil_araddr,
   input  logic [2:0]                  s1_axil_arprot,
   input  logic                        s1_axil_arvalid,
   output logic                        s1_axil_arready,
   output logic [data_width_p-1:0]     s1_axil_rdata,
   output logic [1:0]                  s1_axil_rresp,
   output logic                        s1_axil_rvalid,
   input  logic                        s1_axil_rready,

   output logic [addr_width_p-1:0]     m_axil_awaddr,
   output logic [2:0]                  m_axil_awprot,
   output logic                        m_axil_awvalid,
   input  logic                        m_axil_awready,
   output logic [data_width_p-1:0]     m_axil_wdata,
   output logic [data_width_p/8-1:0]   m_axil_wstrb,
   output logic                        m_axil_wvalid,
   input  logic                        m_axil_wready,
   input  logic [1:0]                  m_axil_bresp,
   input  logic                        m_axil_bvalid,
   output logic                        m_axil_bready,
   output logic [addr_width_p-1:0]     m_axil_araddr,
   output logic [2:0]                  m_axil_arprot,
   output logic                        m_axil_arvalid,
   input  logic                        m_axil_arready,
   input  logic [data_width_p-1:0]     m_axil_rdata,
   input  logic [1:0]                  m_axil_rresp,
   input  logic                        m_axil_rvalid,
   output logic                        m_axil_rready,

   output logic                        busy_o,
   output logic                        grant_id_o
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      W_REQ  = 3'd1,
      W_RESP = 3'd2,
      R_REQ  = 3'd3,
      R_RESP = 3'd4
   } state_e;

   state_e                      state_q, state_n;
   logic                        ptr_q;
   logic                        grant_q;
   logic                        aw_done_q;
   logic                        w_done_q;
   logic [addr_width_p-1:0]     addr_q;
   logic [2:0]                  prot_q;
   logic [data_width_p-1:0]     wdata_q;
   logic [data_width_p/8-1:0]   wstrb_q;

   logic [1:0] w_elig;
   logic [1:0] r_elig;
   logic [1:0] elig;
   logic       winner;
   logic       grant_v;
   logic       grant_write;
   logic       aw_fin;
   logic       w_fin;

   // Arbitration: write beats read inside a requester; the pointer only
   // matters when both requesters have something to offer.
   assign w_elig = {s1_axil_awvalid & s1_axil_wvalid, s0_axil_awvalid & s0_axil_wvalid};
   assign r_elig = {s1_axil_arvalid, s0_axil_arvalid};
   assign elig   = w_elig | r_elig;

   always_comb begin
      winner = 1'b0;
      if (elig == 2'b11) winner = ptr_q;
      else               winner = elig[1];
   end

   // Reset gates the grant so no requester sees a handshake that the
   // register reset would immediately discard.
   assign grant_v     = (state_q == IDLE) && (elig != 2'b00) && !reset_i;
   assign grant_write = w_elig[winner];

   assign aw_fin = aw_done_q | (m_axil_awvalid & m_axil_awready);
   assign w_fin  = w_done_q  | (m_axil_wvalid  & m_axil_wready);

   // Captured request fields; AW and AR share one address/prot register
   // since only one transaction is ever outstanding.
   assign m_axil_awaddr = addr_q;
   assign m_axil_awprot = prot_q;
   assign m_axil_araddr = addr_q;
   assign m_axil_arprot = prot_q;
   assign m_axil_wdata  = wdata_q;
   assign m_axil_wstrb  = wstrb_q;

   // Response payloads fan out unconditionally; only the valids are steered.
   assign s0_axil_bresp = m_axil_bresp;
   assign s1_axil_bresp = m_axil_bresp;
   assign s0_axil_rdata = m_axil_rdata;
   assign s1_axil_rdata = m_axil_rdata;
   assign s0_axil_rresp = m_axil_rresp;
   assign s1_axil_rresp = m_axil_rresp;

   assign busy_o     = (state_q != IDLE);
   assign grant_id_o = grant_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= IDLE;
         ptr_q     <= 1'b0;
         grant_q   <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         addr_q    <= '0;
         prot_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
      end else begin
         state_q <= state_n;
         if (grant_v) begin
            grant_q   <= winner;
            ptr_q     <= ~winner;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            if (grant_write) begin
               addr_q  <= winner ? s1_axil_awaddr : s0_axil_awaddr;
               prot_q  <= winner ? s1_axil_awprot : s0_axil_awprot;
               wdata_q <= winner ? s1_axil_wdata  : s0_axil_wdata;
               wstrb_q <= winner ? s1_axil_wstrb  : s0_axil_wstrb;
            end else begin
               addr_q  <= winner ? s1_axil_araddr : s0_axil_araddr;
               prot_q  <= winner ? s1_axil_arprot : s0_axil_arprot;
            end
         end else if (state_q == W_REQ) begin
            aw_done_q <= aw_fin;
            w_done_q  <= w_fin;
         end
      end
   end

   always_comb begin
      state_n = state_q;
      case (state_q)
         IDLE:    if (grant_v) state_n = grant_write ? W_REQ : R_REQ;
         W_REQ:   if (aw_fin && w_fin) state_n = W_RESP;
         W_RESP:  if (m_axil_bvalid && m_axil_bready) state_n = IDLE;
         R_REQ:   if (m_axil_arready) state_n = R_RESP;
         R_RESP:  if (m_axil_rvalid && m_axil_rready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      s0_axil_awready = 1'b0;
      s0_axil_wready  = 1'b0;
      s0_axil_arready = 1'b0;
      s0_axil_bvalid  = 1'b0;
      s0_axil_rvalid  = 1'b0;
      s1_axil_awready = 1'b0;
      s1_axil_wready  = 1'b0;
      s1_axil_arready = 1'b0;
      s1_axil_bvalid  = 1'b0;
      s1_axil_rvalid  = 1'b0;
      m_axil_awvalid  = 1'b0;
      m_axil_wvalid   = 1'b0;
      m_axil_arvalid  = 1'b0;
      m_axil_bready   = 1'b0;
      m_axil_rready   = 1'b0;
      case (state_q)
         IDLE: begin
            if (grant_v) begin
               if (grant_write) begin
                  if (winner) begin
                     s1_axil_awready = 1'b1;
                     s1_axil_wready  = 1'b1;
                  end else begin
                     s0_axil_awready = 1'b1;
                     s0_axil_wready  = 1'b1;
                  end
               end else begin
                  if (winner) s1_axil_arready = 1'b1;
                  else        s0_axil_arready = 1'b1;
               end
            end
         end
         W_REQ: begin
            m_axil_awvalid = ~aw_done_q;
            m_axil_wvalid  = ~w_done_q;
         end
         W_RESP: begin
            m_axil_bready = grant_q ? s1_axil_bready : s0_axil_bready;
            if (grant_q) s1_axil_bvalid = m_axil_bvalid;
            else         s0_axil_bvalid = m_axil_bvalid;
         end
         R_REQ: begin
            m_axil_arvalid = 1'b1;
         end
         R_RESP: begin
            m_axil_rready = grant_q ? s1_axil_rready : s0_axil_rready;
            if (grant_q) s1_axil_rvalid = m_axil_rvalid;
            else         s0_axil_rvalid = m_axil_rvalid;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_axil_master_arbiter.sv
// Directed testbench for axil_master_arbiter. The bench plays both requesters
// and the downstream slave, cycle by cycle, with hand-computed expectations.

module tb_axil_master_arbiter;

   logic        clk_i = 1'b0;
   logic        reset_i;

   logic [31:0] s0_axil_awaddr, s1_axil_awaddr, s0_axil_araddr, s1_axil_araddr;
   logic [2:0]  s0_axil_awprot, s1_axil_awprot, s0_axil_arprot, s1_axil_arprot;
   logic        s0_axil_awvalid, s1_axil_awvalid, s0_axil_awready, s1_axil_awready;
   logic [31:0] s0_axil_wdata, s1_axil_wdata;
   logic [3:0]  s0_axil_wstrb, s1_axil_wstrb;
   logic        s0_axil_wvalid, s1_axil_wvalid, s0_axil_wready, s1_axil_wready;
   logic [1:0]  s0_axil_bresp, s1_axil_bresp;
   logic        s0_axil_bvalid, s1_axil_bvalid, s0_axil_bready, s1_axil_bready;
   logic        s0_axil_arvalid, s1_axil_arvalid, s0_axil_arready, s1_axil_arready;
   logic [31:0] s0_axil_rdata, s1_axil_rdata;
   logic [1:0]  s0_axil_rresp, s1_axil_rresp;
   logic        s0_axil_rvalid, s1_axil_rvalid, s0_axil_rready, s1_axil_rready;

   logic [31:0] m_axil_awaddr, m_axil_araddr, m_axil_wdata, m_axil_rdata;
   logic [2:0]  m_axil_awprot, m_axil_arprot;
   logic [3:0]  m_axil_wstrb;
   logic        m_axil_awvalid, m_axil_awready, m_axil_wvalid, m_axil_wready;
   logic [1:0]  m_axil_bresp, m_axil_rresp;
   logic        m_axil_bvalid, m_axil_bready, m_axil_arvalid, m_axil_arready;
   logic        m_axil_rvalid, m_axil_rready;
   logic        busy_o, grant_id_o;

   int errors = 0;
   int checks = 0;

   always #5 clk_i = ~clk_i;

   axil_master_arbiter #(.addr_width_p(32), .data_width_p(32)) dut (
      .clk_i(clk_i), .reset_i(reset_i),
      .s0_axil_awaddr(s0_axil_awaddr), .s0_axil_awprot(s0_axil_awprot),
      .s0_axil_awvalid(s0_axil_awvalid), .s0_axil_awready(s0_axil_awready),
      .s0_axil_wdata(s0_axil_wdata), .s0_axil_wstrb(s0_axil_wstrb),
      .s0_axil_wvalid(s0_axil_wvalid), .s0_axil_wready(s0_axil_wready),
      .s0_axil_bresp(s0_axil_bresp), .s0_axil_bvalid(s0_axil_bvalid),
      .s0_axil_bready(s0_axil_bready),
      .s0_axil_araddr(s0_axil_araddr), .s0_axil_arprot(s0_axil_arprot),
      .s0_axil_arvalid(s0_axil_arvalid), .s0_axil_arready(s0_axil_arready),
      .s0_axil_rdata(s0_axil_rdata), .s0_axil_rresp(s0_axil_rresp),
      .s0_axil_rvalid(s0_axil_rvalid), .s0_axil_rready(s0_axil_rready),
      .s1_axil_awaddr(s1_axil_awaddr), .s1_axil_awprot(s1_axil_awprot),
      .s1_axil_awvalid(s1_axil_awvalid), .s1_axil_awready(s1_axil_awready),
      .s1_axil_wdata(s1_axil_wdata), .s1_axil_wstrb(s1_axil_wstrb),
      .s1_axil_wvalid(s1_axil_wvalid), .s1_axil_wready(s1_axil_wready),
      .s1_axil_bresp(s1_axil_bresp), .s1_axil_bvalid(s1_axil_bvalid),
      .s1_axil_bready(s1_axil_bready),
      .s1_axil_araddr(s1_axil_araddr), .s1_axil_arprot(s1_axil_arprot),
      .s1_axil_arvalid(s1_axil_arvalid), .s1_axil_arready(s1_axil_arready),
      .s1_axil_rdata(s1_axil_rdata), .s1_axil_rresp(s1_axil_rresp),
      .s1_axil_rvalid(s1_axil_rvalid), .s1_axil_rready(s1_axil_rready),
      .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
      .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
      .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
      .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
      .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid),
      .m_axil_bready(m_axil_bready),
      .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
      .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
      .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
      .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready),
      .busy_o(busy_o), .grant_id_o(grant_id_o)
   );

   // Inputs change 1 time unit after a rising edge; outputs are read 1 unit later.
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      reset_i = 1'b1;
      step();
      step();
      s0_axil_awvalid = 1'b1; s0_axil_wvalid = 1'b1; s0_axil_arvalid = 1'b1;
      #1;
      checks++;
      if ({s0_axil_awready, s0_axil_wready, s0_axil_arready} !== 3'b000) begin
         errors++;
         $display("FAIL reset_readies: got %b expected 000", {s0_axil_awready, s0_axil_wready, s0_axil_arready});
      end
      checks++;
      if ({busy_o, grant_id_o} !== 2'b00) begin
         errors++;
         $display("FAIL reset_busy_grant: got %b expected 00", {busy_o, grant_id_o});
      end
      checks++;
      if ({m_axil_awvalid, m_axil_wvalid, m_axil_arvalid, m_axil_bready, m_axil_rready} !== 5'b00000) begin
         errors++;
         $display("FAIL reset_master_ctrl: got %b expected 00000",
                  {m_axil_awvalid, m_axil_wvalid, m_axil_arvalid, m_axil_bready, m_axil_rready});
      end
      s0_axil_awvalid = 1'b0; s0_axil_wvalid = 1'b0; s0_axil_arvalid = 1'b0;
      reset_i = 1'b0;
      step();
      checks++;
      if ({m_axil_awaddr, m_axil_wdata, m_axil_wstrb, busy_o} !== 69'd0) begin
         errors++;
         $display("FAIL reset_regs: got %h %h %h busy=%b expected zeros", m_axil_awaddr, m_axil_wdata, m_axil_wstrb, busy_o);
      end
   endtask

   task automatic test_single_write();
      m_axil_awready = 1'b1; m_axil_wready = 1'b1;
      s0_axil_awaddr = 32'h1000_0040; s0_axil_awprot = 3'b000; s0_axil_awvalid = 1'b1;
      s0_axil_wdata = 32'hDEAD_BEEF; s0_axil_wstrb = 4'hF; s0_axil_wvalid = 1'b1;
      #1;
      checks++;
      if ({s0_axil_awready, s0_axil_wready, s1_axil_awready, s1_axil_wready, s0_axil_arready} !== 5'b11000) begin
         errors++;
         $display("FAIL wr_grant_readies: got %b expected 11000",
                  {s0_axil_awready, s0_axil_wready, s1_axil_awready, s1_axil_wready, s0_axil_arready});
      end
      step();
      s0_axil_awvalid = 1'b0; s0_axil_wvalid = 1'b0;
      checks++;
      if ({m_axil_awvalid, m_axil_wvalid, busy_o, grant_id_o} !== 4'b1110) begin
         errors++;
         $display("FAIL wr_req_valids: got %b expected 1110", {m_axil_awvalid, m_axil_wvalid, busy_o, grant_id_o});
      end
      checks++;
      if ({m_axil_awaddr, m_axil_wdata, m_axil_wstrb} !== {32'h1000_0040, 32'hDEAD_BEEF, 4'hF}) begin
         errors++;
         $display("FAIL wr_req_payload: got %h %h %h expected 10000040 deadbeef f", m_axil_awaddr, m_axil_wdata, m_axil_wstrb);
      end
      step();
      checks++;
      if ({m_axil_awvalid, m_axil_wvalid, busy_o} !== 3'b001) begin
         errors++;
         $display("FAIL wr_resp_entry: got %b expected 001", {m_axil_awvalid, m_axil_wvalid, busy_o});
      end
      m_axil_bvalid = 1'b1; m_axil_bresp = 2'b00; s0_axil_bready = 1'b1; s1_axil_bready = 1'b1;
      #1;
      checks++;
      if ({s0_axil_bvalid, s1_axil_bvalid, m_axil_bready, s1_axil_awready, s1_axil_wready, s0_axil_bresp} !== 7'b1010000) begin
         errors++;
         $display("FAIL wr_b_route: got %b expected 1010000",
                  {s0_axil_bvalid, s1_axil_bvalid, m_axil_bready, s1_axil_awready, s1_axil_wready, s0_axil_bresp});
      end
      step();
      m_axil_bvalid = 1'b0; s0_axil_bready = 1'b0; s1_axil_bready = 1'b0;
      #1;
      checks++;
      if ({busy_o, s0_axil_bvalid} !== 2'b00) begin
         errors++;
         $display("FAIL wr_back_idle: got %b expected 00", {busy_o, s0_axil_bvalid});
      end
   endtask

   task automatic test_round_robin_reads();
      reset_i = 1'b1;
      step();
      reset_i = 1'b0;
      m_axil_arready = 1'b1;
      s0_axil_araddr = 32'h10; s1_axil_araddr = 32'h20;
      s0_axil_arvalid = 1'b1; s1_axil_arvalid = 1'b1;
      s0_axil_rready = 1'b1; s1_axil_rready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         logic g;
         g = (i % 2) == 1;
         #1;
         checks++;
         if ({s1_axil_arready, s0_axil_arready} !== (g ? 2'b10 : 2'b01)) begin
            errors++;
            $display("FAIL rr_grant round %0d: got %b expected %b", i, {s1_axil_arready, s0_axil_arready}, g ? 2'b10 : 2'b01);
         end
         step();
         checks++;
         if ({m_axil_arvalid, grant_id_o, m_axil_araddr} !== {1'b1, g, (g ? 32'h20 : 32'h10)}) begin
            errors++;
            $display("FAIL rr_ar round %0d: got valid=%b id=%b addr=%h", i, m_axil_arvalid, grant_id_o, m_axil_araddr);
         end
         step();
         m_axil_rvalid = 1'b1; m_axil_rdata = 32'hA000_0000 + i; m_axil_rresp = 2'b00;
         #1;
         checks++;
         if ({s1_axil_rvalid, s0_axil_rvalid, m_axil_rready} !== {g, ~g, 1'b1} ||
             (g ? s1_axil_rdata : s0_axil_rdata) !== 32'hA000_0000 + i) begin
            errors++;
            $display("FAIL rr_r_route round %0d: got rvalid=%b rdata=%h", i, {s1_axil_rvalid, s0_axil_rvalid},
                     g ? s1_axil_rdata : s0_axil_rdata);
         end
         step();
         m_axil_rvalid = 1'b0;
      end
      s0_axil_arvalid = 1'b0; s1_axil_arvalid = 1'b0;
      s0_axil_rready = 1'b0; s1_axil_rready = 1'b0;
   endtask

   task automatic test_write_before_read();
      m_axil_awready = 1'b1; m_axil_wready = 1'b1; m_axil_arready = 1'b1;
      s0_axil_awaddr = 32'h1000_0100; s0_axil_wdata = 32'h0000_00AA; s0_axil_wstrb = 4'h1;
      s0_axil_awvalid = 1'b1; s0_axil_wvalid = 1'b1;
      s0_axil_araddr = 32'h1000_0200; s0_axil_arvalid = 1'b1;
      #1;
      checks++;
      if ({s0_axil_awready, s0_axil_wready, s0_axil_arready} !== 3'b110) begin
         errors++;
         $display("FAIL wr_first_grant: got %b expected 110", {s0_axil_awready, s0_axil_wready, s0_axil_arready});
      end
      step();
      s0_axil_awvalid = 1'b0; s0_axil_wvalid = 1'b0;
      checks++;
      if ({m_axil_awvalid, m_axil_arvalid} !== 2'b10) begin
         errors++;
         $display("FAIL wr_first_req: got %b expected 10", {m_axil_awvalid, m_axil_arvalid});
      end
      step();
      m_axil_bvalid = 1'b1; m_axil_bresp = 2'b00; s0_axil_bready = 1'b1;
      #1;
      checks++;
      if (s0_axil_bvalid !== 1'b1) begin
         errors++;
         $display("FAIL wr_first_b: got %b expected 1", s0_axil_bvalid);
      end
      step();
      m_axil_bvalid = 1'b0; s0_axil_bready = 1'b0;
      #1;
      checks++;
      if ({busy_o, s0_axil_arready} !== 2'b01) begin
         errors++;
         $display("FAIL rd_on_reentry: got %b expected 01", {busy_o, s0_axil_arready});
      end
      step();
      s0_axil_arvalid = 1'b0;
      checks++;
      if ({m_axil_arvalid, m_axil_araddr} !== {1'b1, 32'h1000_0200}) begin
         errors++;
         $display("FAIL rd_after_wr_ar: got valid=%b addr=%h expected 1 10000200", m_axil_arvalid, m_axil_araddr);
      end
      step();
      m_axil_rvalid = 1'b1; m_axil_rresp = 2'b00; s0_axil_rready = 1'b1;
      #1;
      checks++;
      if ({s0_axil_rvalid, m_axil_rready} !== 2'b11) begin
         errors++;
         $display("FAIL rd_after_wr_r: got %b expected 11", {s0_axil_rvalid, m_axil_rready});
      end
      step();
      m_axil_rvalid = 1'b0; s0_axil_rready = 1'b0;
   endtask

   task automatic test_aw_stall();
      m_axil_awready = 1'b0; m_axil_wready = 1'b1; s1_axil_bready = 1'b1;
      s1_axil_awaddr = 32'h2000_0004; s1_axil_awprot = 3'b010; s1_axil_awvalid = 1'b1;
      s1_axil_wdata = 32'h1234_5678; s1_axil_wstrb = 4'h3; s1_axil_wvalid = 1'b1;
      #1;
      checks++;
      if ({s1_axil_awready, s1_axil_wready, s0_axil_awready} !== 3'b110) begin
         errors++;
         $display("FAIL stall_grant: got %b expected 110", {s1_axil_awready, s1_axil_wready, s0_axil_awready});
      end
      step();
      s1_axil_awvalid = 1'b0; s1_axil_wvalid = 1'b0;
      checks++;
      if ({m_axil_awvalid, m_axil_wvalid, grant_id_o, m_axil_awaddr, m_axil_awprot} !== {3'b111, 32'h2000_0004, 3'b010}) begin
         errors++;
         $display("FAIL stall_req: got v=%b id=%b addr=%h prot=%b", {m_axil_awvalid, m_axil_wvalid}, grant_id_o,
                  m_axil_awaddr, m_axil_awprot);
      end
      for (int k = 2; k <= 5; k++) begin
         step();
         checks++;
         if ({m_axil_awvalid, m_axil_wvalid, m_axil_bready, busy_o} !== 4'b1001) begin
            errors++;
            $display("FAIL stall_aw_hold cycle %0d: got %b expected 1001", k,
                     {m_axil_awvalid, m_axil_wvalid, m_axil_bready, busy_o});
         end
      end
      m_axil_awready = 1'b1;
      step();
      m_axil_awready = 1'b0;
      checks++;
      if ({m_axil_awvalid, m_axil_wvalid, busy_o} !== 3'b001) begin
         errors++;
         $display("FAIL stall_wresp_entry: got %b expected 001", {m_axil_awvalid, m_axil_wvalid, busy_o});
      end
      m_axil_bvalid = 1'b1; m_axil_bresp = 2'b00;
      #1;
      checks++;
      if ({s1_axil_bvalid, s0_axil_bvalid, m_axil_bready} !== 3'b101) begin
         errors++;
         $display("FAIL stall_b_route: got %b expected 101", {s1_axil_bvalid, s0_axil_bvalid, m_axil_bready});
      end
      step();
      m_axil_bvalid = 1'b0; s1_axil_bready = 1'b0;
      checks++;
      if (busy_o !== 1'b0) begin
         errors++;
         $display("FAIL stall_idle: got busy=%b expected 0", busy_o);
      end
   endtask

   task automatic test_slverr_read();
      m_axil_arready = 1'b1;
      s1_axil_araddr = 32'h3000_0000; s1_axil_arvalid = 1'b1; s1_axil_rready = 1'b0;
      #1;
      checks++;
      if ({s1_axil_arready, s0_axil_arready} !== 2'b10) begin
         errors++;
         $display("FAIL slverr_grant: got %b expected 10", {s1_axil_arready, s0_axil_arready});
      end
      step();
      s1_axil_arvalid = 1'b0;
      checks++;
      if ({m_axil_arvalid, grant_id_o} !== 2'b11) begin
         errors++;
         $display("FAIL slverr_ar: got %b expected 11", {m_axil_arvalid, grant_id_o});
      end
      step();
      m_axil_rvalid = 1'b1; m_axil_rresp = 2'b10; m_axil_rdata = 32'hBAD0_0001;
      #1;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if ({s1_axil_rvalid, s1_axil_rresp, m_axil_rready, s0_axil_rvalid, s1_axil_rdata} !== {5'b11000, 32'hBAD0_0001}) begin
            errors++;
            $display("FAIL slverr_hold cycle %0d: got rvalid=%b rresp=%b mrready=%b s0rvalid=%b rdata=%h", k,
                     s1_axil_rvalid, s1_axil_rresp, m_axil_rready, s0_axil_rvalid, s1_axil_rdata);
         end
         step();
      end
      s1_axil_rready = 1'b1;
      #1;
      checks++;
      if ({m_axil_rready, s1_axil_rvalid, s1_axil_rresp} !== 4'b1110) begin
         errors++;
         $display("FAIL slverr_release: got %b expected 1110", {m_axil_rready, s1_axil_rvalid, s1_axil_rresp});
      end
      step();
      m_axil_rvalid = 1'b0; s1_axil_rready = 1'b0; m_axil_rresp = 2'b00;
      checks++;
      if (busy_o !== 1'b0) begin
         errors++;
         $display("FAIL slverr_idle: got busy=%b expected 0", busy_o);
      end
   endtask

   task automatic test_reset_mid_transaction();
      m_axil_arready = 1'b1;
      s0_axil_araddr = 32'h40; s0_axil_arvalid = 1'b1;
      step();
      s0_axil_arvalid = 1'b0;
      step();
      m_axil_rvalid = 1'b1; m_axil_rdata = 32'h5555_AAAA; s0_axil_rready = 1'b0;
      #1;
      checks++;
      if ({busy_o, s0_axil_rvalid} !== 2'b11) begin
         errors++;
         $display("FAIL midrst_pre: got %b expected 11", {busy_o, s0_axil_rvalid});
      end
      reset_i = 1'b1;
      step();
      reset_i = 1'b0;
      checks++;
      if ({busy_o, grant_id_o, m_axil_awvalid, m_axil_wvalid, m_axil_arvalid, m_axil_bready, m_axil_rready,
           s0_axil_rvalid, s1_axil_rvalid, m_axil_araddr} !== 41'd0) begin
         errors++;
         $display("FAIL midrst_idle: got busy=%b id=%b v=%b rv=%b addr=%h", busy_o, grant_id_o,
                  {m_axil_awvalid, m_axil_wvalid, m_axil_arvalid, m_axil_bready, m_axil_rready},
                  {s0_axil_rvalid, s1_axil_rvalid}, m_axil_araddr);
      end
      m_axil_rvalid = 1'b0;
      m_axil_awready = 1'b1; m_axil_wready = 1'b1;
      s0_axil_awaddr = 32'h1000_0080; s0_axil_wdata = 32'hCAFE_F00D; s0_axil_wstrb = 4'hF;
      s0_axil_awvalid = 1'b1; s0_axil_wvalid = 1'b1;
      s1_axil_araddr = 32'h50; s1_axil_arvalid = 1'b1;
      #1;
      checks++;
      if ({s0_axil_awready, s0_axil_wready, s1_axil_arready} !== 3'b110) begin
         errors++;
         $display("FAIL midrst_ptr: got %b expected 110", {s0_axil_awready, s0_axil_wready, s1_axil_arready});
      end
      step();
      s0_axil_awvalid = 1'b0; s0_axil_wvalid = 1'b0;
      checks++;
      if ({m_axil_awvalid, m_axil_wvalid, m_axil_awaddr, m_axil_wdata} !== {2'b11, 32'h1000_0080, 32'hCAFE_F00D}) begin
         errors++;
         $display("FAIL midrst_wr_req: got v=%b addr=%h data=%h", {m_axil_awvalid, m_axil_wvalid}, m_axil_awaddr, m_axil_wdata);
      end
      step();
      m_axil_bvalid = 1'b1; m_axil_bresp = 2'b00; s0_axil_bready = 1'b1;
      #1;
      checks++;
      if ({s0_axil_bvalid, s1_axil_bvalid, s0_axil_bresp} !== 4'b1000) begin
         errors++;
         $display("FAIL midrst_wr_b: got %b expected 1000", {s0_axil_bvalid, s1_axil_bvalid, s0_axil_bresp});
      end
      step();
      m_axil_bvalid = 1'b0; s0_axil_bready = 1'b0; s1_axil_arvalid = 1'b0;
      checks++;
      if (busy_o !== 1'b0) begin
         errors++;
         $display("FAIL midrst_done: got busy=%b expected 0", busy_o);
      end
   endtask

   initial begin
      reset_i = 1'b1;
      s0_axil_awaddr = '0; s0_axil_awprot = '0; s0_axil_awvalid = 1'b0;
      s0_axil_wdata = '0; s0_axil_wstrb = '0; s0_axil_wvalid = 1'b0; s0_axil_bready = 1'b0;
      s0_axil_araddr = '0; s0_axil_arprot = '0; s0_axil_arvalid = 1'b0; s0_axil_rready = 1'b0;
      s1_axil_awaddr = '0; s1_axil_awprot = '0; s1_axil_awvalid = 1'b0;
      s1_axil_wdata = '0; s1_axil_wstrb = '0; s1_axil_wvalid = 1'b0; s1_axil_bready = 1'b0;
      s1_axil_araddr = '0; s1_axil_arprot = '0; s1_axil_arvalid = 1'b0; s1_axil_rready = 1'b0;
      m_axil_awready = 1'b0; m_axil_wready = 1'b0; m_axil_bresp = '0; m_axil_bvalid = 1'b0;
      m_axil_arready = 1'b0; m_axil_rdata = '0; m_axil_rresp = '0; m_axil_rvalid = 1'b0;

      test_reset();
      test_single_write();
      test_round_robin_reads();
      test_write_before_read();
      test_aw_stall();
      test_slverr_read();
      test_reset_mid_transaction();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
